// File: rtl/inst_prefetch_unit_if.sv
// Bundle of the fetch-side buses of inst_prefetch_unit.
//   imem_*        : byte-wide instruction memory request/ack/data
//   redirect*     : flush and restart request from the next-PC mux
//   inst_*        : FIFO head toward decode (valid/ready handshake)
//   fifo_count    : occupied FIFO entries
//   misalign_err  : sticky misaligned-redirect flag (only with PF_ALIGN_CHECK_EN)
// master = prefetch unit side, slave = memory/datapath side.
interface inst_prefetch_unit_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_ack;
  logic [7:0]    imem_rdata;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          inst_valid;
  logic          inst_ready;
  logic [31:0]   inst_word;
  logic [31:0]   inst_pc;
  logic [31:0]   inst_pc_plus4;
  logic [CW-1:0] fifo_count;
`ifdef PF_ALIGN_CHECK_EN
  logic          misalign_err;
`endif

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    input  redirect, redirect_pc,
    output inst_valid,
    input  inst_ready,
    output inst_word, inst_pc, inst_pc_plus4, fifo_count
`ifdef PF_ALIGN_CHECK_EN
    , output misalign_err
`endif
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    output redirect, redirect_pc,
    input  inst_valid,
    output inst_ready,
    input  inst_word, inst_pc, inst_pc_plus4, fifo_count
`ifdef PF_ALIGN_CHECK_EN
    , input misalign_err
`endif
  );
endinterface

// File: rtl/inst_prefetch_unit.sv
// Instruction prefetch unit: fetches one byte per accepted transfer, assembles
// big-endian 32-bit words and queues {word, pc} in a DEPTH-entry FIFO.
// A redirect flushes everything and restarts fetch at the new word address.
// Ports: clk, rst_n (synchronous, active low), bus (inst_prefetch_unit_if.master).
// Optional macro PF_ALIGN_CHECK_EN: misaligned redirects raise a sticky
// misalign_err and park the unit in HALT until an aligned redirect or reset.
module inst_prefetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic                  clk,
  input logic                  rst_n,
  inst_prefetch_unit_if.master bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_FULL  = 2'd1
`ifdef PF_ALIGN_CHECK_EN
    , ST_HALT = 2'd2
`endif
  } state_t;

  state_t        state;
  logic [31:0]   fpc;
  logic [1:0]    bcnt;
  logic [23:0]   part;
  logic [31:0]   word_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          req;
  logic          valid;
  logic          xfer;
  logic          push;
  logic          pop;
  logic [CW-1:0] count_nxt;

  // Handshake decode; a redirect cycle suppresses both transfer and pop.
  always_comb begin
    req       = (state == ST_FETCH) && !bus.redirect;
    valid     = (count != '0) && !bus.redirect;
    xfer      = req && bus.imem_ack;
    push      = xfer && (bcnt == 2'd3);
    pop       = valid && bus.inst_ready;
    count_nxt = count + CW'(push) - CW'(pop);
  end

  assign bus.imem_req      = req;
  assign bus.imem_addr     = fpc + 32'(bcnt);
  assign bus.inst_valid    = valid;
  assign bus.inst_word     = word_q[rd_ptr];
  assign bus.inst_pc       = pc_q[rd_ptr];
  assign bus.inst_pc_plus4 = pc_q[rd_ptr] + 32'd4;
  assign bus.fifo_count    = count;

`ifdef PF_ALIGN_CHECK_EN
  logic misalign;
  assign bus.misalign_err = misalign;
`else
  logic unused_pc_lo;
  assign unused_pc_lo = ^bus.redirect_pc[1:0];
`endif

  // Fetch state, byte assembly, FIFO storage and FSM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_FETCH;
      fpc    <= RESET_PC;
      bcnt   <= '0;
      part   <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        word_q[i] <= '0;
        pc_q[i]   <= '0;
      end
`ifdef PF_ALIGN_CHECK_EN
      misalign <= 1'b0;
`endif
    end else if (bus.redirect) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      bcnt   <= '0;
      part   <= '0;
      fpc    <= {bus.redirect_pc[31:2], 2'b00};
`ifdef PF_ALIGN_CHECK_EN
      if (bus.redirect_pc[1:0] != 2'b00) begin
        state    <= ST_HALT;
        misalign <= 1'b1;
      end else begin
        state    <= ST_FETCH;
        misalign <= 1'b0;
      end
`else
      state <= ST_FETCH;
`endif
    end else begin
      if (xfer) begin
        // Byte 0 is the most significant byte of the word.
        case (bcnt)
          2'd0:    part[23:16] <= bus.imem_rdata;
          2'd1:    part[15:8]  <= bus.imem_rdata;
          2'd2:    part[7:0]   <= bus.imem_rdata;
          default: begin
            word_q[wr_ptr] <= {part, bus.imem_rdata};
            pc_q[wr_ptr]   <= fpc;
            wr_ptr         <= wr_ptr + PW'(1);
            fpc            <= fpc + 32'd4;
          end
        endcase
        bcnt <= bcnt + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count_nxt;
      // Fetch only while a slot is free, so a push is never blocked.
      case (state)
        ST_FETCH: if (count_nxt == CW'(DEPTH)) state <= ST_FULL;
        ST_FULL:  if (count_nxt <  CW'(DEPTH)) state <= ST_FETCH;
        default:  ;
      endcase
    end
  end
endmodule

// File: tb/tb_inst_prefetch_unit.sv
// Self-checking bench for inst_prefetch_unit: directed stimulus with a
// scoreboard queue of expected {word, pc} popped by a handshake monitor.
module tb_inst_prefetch_unit;
  logic clk;
  logic rst_n;

  int n_tests;
  int n_fail;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];

  inst_prefetch_unit_if #(.DEPTH(4)) bus ();

  inst_prefetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: fixed program bytes at 0..3, pattern elsewhere.
  function automatic logic [7:0] byte_at(input logic [31:0] a);
    case (a)
      32'd0:   return 8'h8C;
      32'd1:   return 8'h22;
      32'd2:   return 8'h00;
      32'd3:   return 8'h04;
      default: return a[7:0] ^ a[31:24] ^ 8'hA5;
    endcase
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] p);
    return {byte_at(p), byte_at(p + 32'd1), byte_at(p + 32'd2), byte_at(p + 32'd3)};
  endfunction

  assign bus.imem_rdata = byte_at(bus.imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_from(input logic [31:0] pc, input int n);
    exp_t e;
    logic [31:0] p;
    p = pc;
    for (int i = 0; i < n; i++) begin
      e.word = word_at(p);
      e.pc   = p;
      exp_q.push_back(e);
      p = p + 32'd4;
    end
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    bus.redirect    = 1'b1;
    bus.redirect_pc = pc;
    step();
    bus.redirect    = 1'b0;
    exp_q.delete();
  endtask

  // Monitor: every accepted head entry is compared against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.inst_valid && bus.inst_ready) begin
      if (exp_q.size() == 0) begin
        check("pop_unexpected_pc", bus.inst_pc, 32'hDEAD_BEEF);
      end else begin
        e = exp_q.pop_front();
        check("pop_word", bus.inst_word, e.word);
        check("pop_pc", bus.inst_pc, e.pc);
        check("pop_pc_plus4", bus.inst_pc_plus4, e.pc + 32'd4);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] t4_addr [7] = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd2, 32'd3, 32'd3};
  logic        t4_ack  [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    n_tests         = 0;
    n_fail          = 0;
    rst_n           = 1'b0;
    bus.imem_ack    = 1'b1;
    bus.inst_ready  = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;

    // Reset state
    step();
    check("rst_valid", 32'(bus.inst_valid), 32'd0);
    check("rst_count", 32'(bus.fifo_count), 32'd0);
    check("rst_addr", bus.imem_addr, 32'h0);
    check("rst_word", bus.inst_word, 32'h0);
    check("rst_pc", bus.inst_pc, 32'h0);
    check("rst_req", 32'(bus.imem_req), 32'd1);
    rst_n = 1'b1;
    expect_from(32'h0, 8);

    // 1: first word after four edges
    step(3);
    check("t1_valid_early", 32'(bus.inst_valid), 32'd0);
    step();
    check("t1_valid", 32'(bus.inst_valid), 32'd1);
    check("t1_word", bus.inst_word, 32'h8C22_0004);
    check("t1_pc", bus.inst_pc, 32'h0);
    check("t1_pc4", bus.inst_pc_plus4, 32'h4);
    check("t1_addr", bus.imem_addr, 32'h4);

    // 2: fill to DEPTH, stall, one pop resumes fetch
    step(12);
    check("t2_count_full", 32'(bus.fifo_count), 32'd4);
    check("t2_req_full", 32'(bus.imem_req), 32'd0);
    check("t2_addr_full", bus.imem_addr, 32'h10);
    step(2);
    check("t2_addr_held", bus.imem_addr, 32'h10);
    check("t2_count_held", 32'(bus.fifo_count), 32'd4);
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
    check("t2_count_pop", 32'(bus.fifo_count), 32'd3);
    check("t2_req_resume", 32'(bus.imem_req), 32'd1);
    check("t2_head_pc", bus.inst_pc, 32'h4);

    // 3: redirect with partial word and two queued entries
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
    step();
    check("t3_addr_partial", bus.imem_addr, 32'h12);
    check("t3_count_pre", 32'(bus.fifo_count), 32'd2);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h40;
    #1;
    check("t3_req_during", 32'(bus.imem_req), 32'd0);
    check("t3_valid_during", 32'(bus.inst_valid), 32'd0);
    do_redirect(32'h40);
    expect_from(32'h40, 8);
    check("t3_count", 32'(bus.fifo_count), 32'd0);
    check("t3_valid", 32'(bus.inst_valid), 32'd0);
    check("t3_addr", bus.imem_addr, 32'h40);
    step(4);
    check("t3_first_valid", 32'(bus.inst_valid), 32'd1);
    check("t3_first_pc", bus.inst_pc, 32'h40);
    bus.inst_ready = 1'b1;
    step(8);
    bus.inst_ready = 1'b0;

    // 4: gapped acks hold the address
    bus.imem_ack = 1'b0;
    do_redirect(32'h0);
    expect_from(32'h0, 4);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("t4_addr_%0d", i), bus.imem_addr, t4_addr[i]);
      if (i == 6) check("t4_valid_early", 32'(bus.inst_valid), 32'd0);
      bus.imem_ack = t4_ack[i];
      step();
    end
    bus.imem_ack = 1'b1;
    check("t4_valid", 32'(bus.inst_valid), 32'd1);
    check("t4_count", 32'(bus.fifo_count), 32'd1);
    check("t4_word", bus.inst_word, 32'h8C22_0004);

    // 5: reset mid-word with entries queued
    step(9);
    check("t5_count_pre", 32'(bus.fifo_count), 32'd3);
    check("t5_addr_pre", bus.imem_addr, 32'hD);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_q.delete();
    expect_from(32'h0, 4);
    check("t5_count", 32'(bus.fifo_count), 32'd0);
    check("t5_valid", 32'(bus.inst_valid), 32'd0);
    check("t5_addr", bus.imem_addr, 32'h0);
    step(4);
    check("t5_word", bus.inst_word, 32'h8C22_0004);
    bus.inst_ready = 1'b1;
    step(4);
    bus.inst_ready = 1'b0;

    // 6: PC wrap at top of address space
    do_redirect(32'hFFFF_FFFC);
    expect_from(32'hFFFF_FFFC, 2);
    step(4);
    check("t6_pc", bus.inst_pc, 32'hFFFF_FFFC);
    check("t6_pc4", bus.inst_pc_plus4, 32'h0);
    check("t6_addr", bus.imem_addr, 32'h0);
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;

`ifdef PF_ALIGN_CHECK_EN
    do_redirect(32'h42);
    check("t6_misalign_set", 32'(bus.misalign_err), 32'd1);
    check("t6_halt_req", 32'(bus.imem_req), 32'd0);
    step(3);
    check("t6_halt_count", 32'(bus.fifo_count), 32'd0);
    check("t6_halt_req_hold", 32'(bus.imem_req), 32'd0);
    do_redirect(32'h40);
    expect_from(32'h40, 1);
    check("t6_misalign_clr", 32'(bus.misalign_err), 32'd0);
    check("t6_resume_req", 32'(bus.imem_req), 32'd1);
    check("t6_resume_addr", bus.imem_addr, 32'h40);
    step(4);
    check("t6_resume_pc", bus.inst_pc, 32'h40);
`else
    do_redirect(32'h42);
    expect_from(32'h40, 1);
    check("t6_align_addr", bus.imem_addr, 32'h40);
    step(4);
    check("t6_align_pc", bus.inst_pc, 32'h40);
`endif
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/inst_prefetch_unit.md
Name: inst_prefetch_unit

Overview:
Instruction fetch/prefetch stage sitting directly upstream of the single-cycle datapath's decode/register-read logic. Reads the byte-wide instruction memory one byte per accepted transfer and assembles big-endian 32-bit words. Buffers the words with their PCs in a small FIFO. Flushes and restarts on a branch/jump redirect driven by the datapath's next-PC mux.

Parameters:
DEPTH, 4, FIFO entries (power of 2, >=2)
RESET_PC, 32'h0, fetch address after reset

Ports:
clk  in  1  clock, all state on posedge
rst_n  in  1  synchronous active-low reset
imem_req  out  1  byte read request
imem_addr  out  32  byte address of requested byte
imem_ack  in  1  byte transfer accepted this cycle
imem_rdata  in  8  byte data, valid when imem_req && imem_ack
redirect  in  1  flush and restart fetch
redirect_pc  in  32  new fetch address (word aligned)
inst_valid  out  1  FIFO head valid
inst_ready  in  1  consumer takes head
inst_word  out  32  head instruction
inst_pc  out  32  head PC
inst_pc_plus4  out  32  head PC + 4 (mod 2^32)
fifo_count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- State: fpc (fetch word address), bcnt (0..3), 24-bit partial assembly register, FIFO (word+pc per entry, rd/wr pointers, count), FSM {FETCH, FULL}.
- Reset (rst_n=0 at posedge): fpc=RESET_PC, bcnt=0, count=0, pointers=0, state=FETCH. Outputs after the reset edge: inst_valid=0, fifo_count=0, imem_addr=RESET_PC, inst_word/inst_pc=0. Reset overrides redirect and all other events. imem_req is 1 after reset; this is legal because the reset edge itself performs no transfer.
- imem_req = (state==FETCH) && !redirect. imem_addr = fpc + bcnt.
- Transfer = imem_req && imem_ack. Byte bcnt lands in bits [31-8*bcnt -: 8] (byte 0 -> [31:24]).
- On a transfer with bcnt<3: store the byte and bcnt++. Address is held while imem_ack=0.
- On a transfer with bcnt==3: push {assembled word, fpc}, fpc+=4 (wraps mod 2^32), bcnt=0.
- FETCH->FULL when the resulting count==DEPTH. FULL->FETCH on the edge where a pop makes count<DEPTH. imem_req reasserts the following cycle.
- FETCH is entered only with a free slot, so a push is never blocked.
- Pop = inst_valid && inst_ready. inst_valid = (count!=0) && !redirect. inst_* is read combinationally from the head entry registers.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Redirect (priority over push/pop): no transfer and no pop that cycle. count=0, pointers=0, bcnt=0, partial word discarded, fpc={redirect_pc[31:2],2'b00}, state=FETCH.
- Latency with imem_ack tied high: first word is pushed on the 4th edge after reset release or redirect. inst_valid=1 from then on. Sustained throughput is 1 word per 4 cycles.
- inst_pc_plus4 = inst_pc + 4, wrapping mod 2^32.

Optional Feature:
Macro PF_ALIGN_CHECK_EN.
- Defined:
  - Adds output misalign_err (1 bit, reset 0).
  - A redirect with redirect_pc[1:0]!=0 sets misalign_err (sticky), flushes as normal, and enters state HALT.
  - In HALT: imem_req=0, no pushes.
  - HALT is left only by reset, or by an aligned redirect, which clears misalign_err and returns to FETCH.
- Undefined: low two bits are silently cleared; no HALT state, no misalign_err port.

Test Plan:
1. Reset, imem_ack=1, inst_ready=0, bytes 8C 22 00 04 at addr 0..3 -> after 4 edges: inst_valid=1, inst_word=32'h8C220004, inst_pc=0, inst_pc_plus4=4, imem_addr=4.
2. DEPTH=4, inst_ready=0, imem_ack=1 -> after 16 edges: fifo_count=4, imem_req=0, imem_addr=0x10 held. Pulse inst_ready one cycle -> fifo_count=3, imem_req=1 next cycle, head inst_pc=4.
3. Redirect with redirect_pc=0x40 while bcnt=2 and fifo_count=2 -> next cycle: fifo_count=0, inst_valid=0, imem_addr=0x40. First word after redirect has inst_pc=0x40; no bytes from the partial word appear.
4. imem_ack pattern 1,0,1,0,1,0,1 -> imem_addr steps 0,1,1,2,2,3,3; word pushed on the 7th edge, equal to a gap-free fetch.
5. rst_n=0 for one cycle with fifo_count=3, bcnt=1 -> next cycle: fifo_count=0, inst_valid=0, imem_addr=RESET_PC.
6. Redirect to 0xFFFFFFFC -> word inst_pc=0xFFFFFFFC, inst_pc_plus4=0, next imem_addr=0x0. With PF_ALIGN_CHECK_EN, redirect to 0x42 -> misalign_err=1, imem_req=0. A following redirect to 0x40 clears it and fetch resumes.
